// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with mid-bit sampling, framing-error detection and line-break recovery.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_key,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 rx_s;
    logic                 bit_end;

    assign rx_s    = sync_q[1];
    assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    logic par_bad_q;
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_key) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], rx};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_s) state_q <= START;
                end
                START: begin
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q[idx_q] <= rx_s;
                        cnt_q          <= '0;
                        if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else idx_q <= idx_q + 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        par_bad_q <= rx_s ^ (^shift_q);
                        cnt_q     <= '0;
                        state_q   <= STOP;
                    end else cnt_q <= cnt_q + 1'b1;
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                            valid_q <= !par_bad_q;
                            perr_q  <= par_bad_q;
`else
                            valid_q <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else cnt_q <= cnt_q + 1'b1;
                end
                // a held-low line must go high before a new start bit can be seen
                BRK: if (rx_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = state_q != IDLE;
endmodule
